dpram_ext: RTL and testbench



---
 rtl/dpram_pkg.sv | 39 +++
 rtl/dpram_clear_fsm.sv | 62 ++++++
 rtl/dpram_ext.sv | 169 ++++++++++++++++
 tb/tb_dpram_ext.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared definitions for the extended dual-port RAM: read-during-write
// mode codes, clear-engine state type and the byte-lane merge helper.
package dpram_pkg;

    localparam int RDW_OLD  = 0;
    localparam int RDW_NEW  = 1;
    localparam int RDW_KEEP = 2;

    // Widest word the merge helper handles; callers zero-extend into it.
    localparam int unsigned MERGE_MAX_W = 128;
    localparam int unsigned MERGE_IDX_W = $clog2(MERGE_MAX_W);

    typedef enum logic {
        READY = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Lanes with en[k]=1 take new_w, the rest keep old_w; bw = bits per lane.
    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0] old_w,
        input logic [MERGE_MAX_W-1:0] new_w,
        input logic [MERGE_MAX_W-1:0] en,
        input int unsigned            bw
    );
        logic [MERGE_MAX_W-1:0] res;
        logic [MERGE_IDX_W-1:0] lane;
        logic [MERGE_IDX_W-1:0] bit_i;
        res = old_w;
        for (int unsigned j = 0; j < MERGE_MAX_W; j++) begin
            lane  = MERGE_IDX_W'(j / bw);
            bit_i = MERGE_IDX_W'(j);
            if (en[lane]) begin
                res[bit_i] = new_w[bit_i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dpram_clear_fsm.sv
// Post-reset clear engine: walks every word once, one per cycle, and
// reports busy while doing so.
module dpram_clear_fsm
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int NUMWORDS       = 1 << ADDR_WIDTH,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_busy,
    output logic [ADDR_WIDTH-1:0] o_clr_addr,
    output logic                  o_clr_we
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUMWORDS - 1);

    clr_state_t            r_state;
    clr_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    // State and counter registers; reset restarts the sweep at address 0
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            if (CLEAR_ON_RESET != 0) begin
                r_state <= CLEAR;
            end else begin
                r_state <= READY;
            end
            r_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and clear write strobe; last word written returns to READY
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_busy      = 1'b0;
        o_clr_we    = 1'b0;
        o_clr_addr  = r_cnt;
        case (r_state)
            CLEAR: begin
                o_busy   = 1'b1;
                o_clr_we = 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = READY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/dpram_ext.sv
// True dual-port RAM with byte enables, read enables, selectable
// read-during-write behaviour, optional output register, same-address
// write arbitration (port A wins) and a post-reset clear engine.
module dpram_ext
    import dpram_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    BYTE_WIDTH     = 8,
    parameter int                    NUMWORDS       = 1 << ADDR_WIDTH,
    parameter string                 MEM_INIT_FILE  = "",
    parameter int                    RDW_MODE       = RDW_OLD,
    parameter int                    OUT_REG        = 0,
    parameter int                    CLEAR_ON_RESET = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    localparam int                   NBYTES         = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  wren_a,
    input  logic [NBYTES-1:0]     byteena_a,
    input  logic                  rden_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  wren_b,
    input  logic [NBYTES-1:0]     byteena_b,
    input  logic                  rden_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  busy,
    output logic                  collision
);

    logic [DATA_WIDTH-1:0] r_mem [NUMWORDS];

    logic                  w_busy;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_clr_we;

    dpram_clear_fsm #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .NUMWORDS       (NUMWORDS),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .i_clk      (clock),
        .i_rst      (reset),
        .o_busy     (w_busy),
        .o_clr_addr (w_clr_addr),
        .o_clr_we   (w_clr_we)
    );

    logic                  w_a_in;
    logic                  w_b_in;
    logic                  w_wr_a;
    logic                  w_wr_b;
    logic                  w_coll;
    logic [ADDR_WIDTH-1:0] w_b_addr;
    logic [DATA_WIDTH-1:0] w_b_data;
    logic [NBYTES-1:0]     w_b_be;
    logic [DATA_WIDTH-1:0] w_old_a;
    logic [DATA_WIDTH-1:0] w_old_b;
    logic [DATA_WIDTH-1:0] w_new_a;
    logic [DATA_WIDTH-1:0] w_new_b;

    assign w_a_in = (32'(address_a) < NUMWORDS);
    assign w_b_in = (32'(address_b) < NUMWORDS);

    // Clear engine borrows port B's write path while busy
    assign w_b_addr = w_busy ? w_clr_addr : address_b;
    assign w_b_data = w_busy ? CLEAR_VALUE : data_b;
    assign w_b_be   = w_busy ? '1 : byteena_b;

    assign w_wr_a = wren_a & w_a_in & ~w_busy;
    assign w_wr_b = w_busy ? w_clr_we : (wren_b & w_b_in);
    assign w_coll = w_wr_a & w_wr_b & (address_a == w_b_addr);

    assign w_old_a = w_a_in ? r_mem[address_a] : '0;
    assign w_old_b = (w_busy | w_b_in) ? r_mem[w_b_addr] : '0;

    // On a same-address dual write, A's lanes are merged on top of B's
    // result so a single write of the combined word replaces both.
    assign w_new_b = DATA_WIDTH'(byte_merge(MERGE_MAX_W'(w_old_b), MERGE_MAX_W'(w_b_data),
                                            MERGE_MAX_W'(w_b_be), BYTE_WIDTH));
    assign w_new_a = DATA_WIDTH'(byte_merge(MERGE_MAX_W'(w_coll ? w_new_b : w_old_a),
                                            MERGE_MAX_W'(data_a),
                                            MERGE_MAX_W'(byteena_a), BYTE_WIDTH));

    // Array write process: both ports in one block, A carries the merged word on collision
    always_ff @(posedge clock) begin
        if (w_wr_a) begin
            r_mem[address_a] <= w_new_a;
        end
        if (w_wr_b && !w_coll) begin
            r_mem[w_b_addr] <= w_new_b;
        end
    end

    logic [DATA_WIDTH-1:0] r_q1_a;
    logic [DATA_WIDTH-1:0] r_q1_b;

    // Port A read register: gated by rden, frozen while busy, RDW mode applied
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q1_a <= '0;
        end else if (!w_busy && rden_a) begin
            if (!w_a_in) begin
                r_q1_a <= '0;
            end else if (wren_a && RDW_MODE == RDW_NEW) begin
                r_q1_a <= w_new_a;
            end else if (!(wren_a && RDW_MODE == RDW_KEEP)) begin
                r_q1_a <= w_old_a;
            end
        end
    end

    // Port B read register: as port A, post-write word includes A's winning lanes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q1_b <= '0;
        end else if (!w_busy && rden_b) begin
            if (!w_b_in) begin
                r_q1_b <= '0;
            end else if (wren_b && RDW_MODE == RDW_NEW) begin
                r_q1_b <= w_coll ? w_new_a : w_new_b;
            end else if (!(wren_b && RDW_MODE == RDW_KEEP)) begin
                r_q1_b <= w_old_b;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] r_q2_a;
        logic [DATA_WIDTH-1:0] r_q2_b;

        // Optional second output stage
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_q2_a <= '0;
                r_q2_b <= '0;
            end else begin
                r_q2_a <= r_q1_a;
                r_q2_b <= r_q1_b;
            end
        end

        assign q_a = r_q2_a;
        assign q_b = r_q2_b;
    end else begin : g_noreg
        assign q_a = r_q1_a;
        assign q_b = r_q1_b;
    end

    logic r_collision;

    // Registered collision pulse, visible the cycle after the dual write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_coll;
        end
    end

    assign busy      = w_busy;
    assign collision = r_collision;

endmodule

// File: tb/tb_dpram_ext.sv
// Bench for dpram_ext: three configurations side by side, directed scenarios
// plus random traffic checked against an array-based reference model.
module tb_dpram_ext;
    import dpram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    logic [3:0]  ad_a [3];
    logic [3:0]  ad_b [3];
    logic [15:0] d_a  [3];
    logic [15:0] d_b  [3];
    logic [1:0]  be_a [3];
    logic [1:0]  be_b [3];
    logic        wr_a [3];
    logic        wr_b [3];
    logic        rd_a [3];
    logic        rd_b [3];

    logic [7:0]  q_a0, q_b0, q_a2, q_b2;
    logic [15:0] q_a1, q_b1;
    logic        busy0, busy1, busy2;
    logic        coll0, coll1, coll2;

    // 0: clear engine, RDW_OLD, 8-bit, 16 words
    dpram_ext #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8), .BYTE_WIDTH(8), .NUMWORDS(16),
        .RDW_MODE(RDW_OLD), .OUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)
    ) u0 (
        .clock(clk), .reset(rst),
        .address_a(ad_a[0]), .data_a(d_a[0][7:0]), .wren_a(wr_a[0]),
        .byteena_a(be_a[0][0:0]), .rden_a(rd_a[0]), .q_a(q_a0),
        .address_b(ad_b[0]), .data_b(d_b[0][7:0]), .wren_b(wr_b[0]),
        .byteena_b(be_b[0][0:0]), .rden_b(rd_b[0]), .q_b(q_b0),
        .busy(busy0), .collision(coll0)
    );

    // 1: 16-bit with two byte lanes, RDW_NEW
    dpram_ext #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .NUMWORDS(16),
        .RDW_MODE(RDW_NEW), .OUT_REG(0), .CLEAR_ON_RESET(0)
    ) u1 (
        .clock(clk), .reset(rst),
        .address_a(ad_a[1]), .data_a(d_a[1]), .wren_a(wr_a[1]),
        .byteena_a(be_a[1]), .rden_a(rd_a[1]), .q_a(q_a1),
        .address_b(ad_b[1]), .data_b(d_b[1]), .wren_b(wr_b[1]),
        .byteena_b(be_b[1]), .rden_b(rd_b[1]), .q_b(q_b1),
        .busy(busy1), .collision(coll1)
    );

    // 2: 12 words, output register, RDW_KEEP
    dpram_ext #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8), .BYTE_WIDTH(8), .NUMWORDS(12),
        .RDW_MODE(RDW_KEEP), .OUT_REG(1), .CLEAR_ON_RESET(0)
    ) u2 (
        .clock(clk), .reset(rst),
        .address_a(ad_a[2]), .data_a(d_a[2][7:0]), .wren_a(wr_a[2]),
        .byteena_a(be_a[2][0:0]), .rden_a(rd_a[2]), .q_a(q_a2),
        .address_b(ad_b[2]), .data_b(d_b[2][7:0]), .wren_b(wr_b[2]),
        .byteena_b(be_b[2][0:0]), .rden_b(rd_b[2]), .q_b(q_b2),
        .busy(busy2), .collision(coll2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    logic [15:0] mem_m [3][16];
    logic [15:0] s1    [3][2];
    logic [15:0] s2    [3][2];
    logic        coll_m[3];
    logic        busy_m[3];
    int          ca    [3];

    function automatic int nw(input int i);
        return (i == 2) ? 12 : 16;
    endfunction
    function automatic int dw(input int i);
        return (i == 1) ? 16 : 8;
    endfunction
    function automatic int rdw(input int i);
        case (i)
            0: return RDW_OLD;
            1: return RDW_NEW;
            default: return RDW_KEEP;
        endcase
    endfunction
    function automatic bit oreg(input int i);
        return (i == 2);
    endfunction
    function automatic bit clr(input int i);
        return (i == 0);
    endfunction

    function automatic logic [15:0] mrg(input logic [15:0] old_w, input logic [15:0] new_w,
                                        input logic [1:0] be);
        logic [15:0] r;
        r = old_w;
        if (be[0]) r[7:0]  = new_w[7:0];
        if (be[1]) r[15:8] = new_w[15:8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < 2; p++) begin
                s1[i][p] = '0;
                s2[i][p] = '0;
            end
            coll_m[i] = 1'b0;
            busy_m[i] = clr(i);
            ca[i]     = 0;
        end
    endtask

    // Applies one rising edge worth of behaviour to every instance
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int          a   [2];
            logic [15:0] dat [2];
            logic [1:0]  be  [2];
            logic        wen [2];
            logic        ren [2];
            logic        ok  [2];
            logic        we  [2];
            logic [15:0] old [2];
            logic [15:0] dm;
            logic [1:0]  bm;
            if (rst) continue;
            for (int p = 0; p < 2; p++) s2[i][p] = s1[i][p];
            if (busy_m[i]) begin
                mem_m[i][ca[i]] = 16'h00A5;
                ca[i]++;
                if (ca[i] == nw(i)) busy_m[i] = 1'b0;
                coll_m[i] = 1'b0;
                continue;
            end
            dm = (dw(i) == 8) ? 16'h00FF : 16'hFFFF;
            bm = (dw(i) == 8) ? 2'b01 : 2'b11;
            a[0] = int'(ad_a[i]); dat[0] = d_a[i] & dm; be[0] = be_a[i] & bm;
            wen[0] = wr_a[i]; ren[0] = rd_a[i];
            a[1] = int'(ad_b[i]); dat[1] = d_b[i] & dm; be[1] = be_b[i] & bm;
            wen[1] = wr_b[i]; ren[1] = rd_b[i];
            for (int p = 0; p < 2; p++) begin
                ok[p]  = (a[p] < nw(i));
                we[p]  = wen[p] && ok[p];
                old[p] = ok[p] ? mem_m[i][a[p]] : 16'h0;
            end
            coll_m[i] = we[0] && we[1] && (a[0] == a[1]);
            // B first, then A on top: A's lanes win, B's other lanes survive
            if (we[1]) mem_m[i][a[1]] = mrg(mem_m[i][a[1]], dat[1], be[1]);
            if (we[0]) mem_m[i][a[0]] = mrg(mem_m[i][a[0]], dat[0], be[0]);
            for (int p = 0; p < 2; p++) begin
                if (ren[p]) begin
                    if (!ok[p])                                s1[i][p] = 16'h0;
                    else if (wen[p] && rdw(i) == RDW_KEEP)     s1[i][p] = s1[i][p];
                    else if (wen[p] && rdw(i) == RDW_NEW)      s1[i][p] = mem_m[i][a[p]];
                    else                                       s1[i][p] = old[p];
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    function automatic logic [15:0] get_q(input int i, input int p);
        case (i)
            0:       return (p == 0) ? {8'h00, q_a0} : {8'h00, q_b0};
            1:       return (p == 0) ? q_a1 : q_b1;
            default: return (p == 0) ? {8'h00, q_a2} : {8'h00, q_b2};
        endcase
    endfunction
    function automatic logic get_busy(input int i);
        return (i == 0) ? busy0 : (i == 1) ? busy1 : busy2;
    endfunction
    function automatic logic get_coll(input int i);
        return (i == 0) ? coll0 : (i == 1) ? coll1 : coll2;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.q_a", i), get_q(i, 0), oreg(i) ? s2[i][0] : s1[i][0]);
            chk($sformatf("u%0d.q_b", i), get_q(i, 1), oreg(i) ? s2[i][1] : s1[i][1]);
            chk($sformatf("u%0d.busy", i), {15'h0, get_busy(i)}, {15'h0, busy_m[i]});
            chk($sformatf("u%0d.collision", i), {15'h0, get_coll(i)}, {15'h0, coll_m[i]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        for (int i = 0; i < 3; i++) begin
            ad_a[i] = '0; ad_b[i] = '0; d_a[i] = '0; d_b[i] = '0;
            be_a[i] = '0; be_b[i] = '0;
            wr_a[i] = 1'b0; wr_b[i] = 1'b0; rd_a[i] = 1'b0; rd_b[i] = 1'b0;
        end
    endtask

    task automatic rand_port(input int i, input int lo, input int hi);
        ad_a[i] = 4'($urandom_range(lo, hi));
        ad_b[i] = 4'($urandom_range(lo, hi));
        d_a[i]  = 16'($urandom);
        d_b[i]  = 16'($urandom);
        be_a[i] = 2'($urandom);
        be_b[i] = 2'($urandom);
        wr_a[i] = 1'($urandom_range(0, 1));
        wr_b[i] = 1'($urandom_range(0, 1));
        rd_a[i] = 1'($urandom_range(0, 1));
        rd_b[i] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 16; k++) mem_m[i][k] = '0;
        idle();
        rst = 1'b1;
        model_reset();
        repeat (2) tick();
        chk("rst_busy0", {15'h0, busy0}, 16'h0001);
        chk("rst_q_a0", {8'h0, q_a0}, 16'h0000);

        // Clear engine: busy exactly 16 cycles, then every word is A5
        rst = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("clear_cycles", 16'(n), 16'd16);
        for (int k = 0; k < 16; k++) begin
            rd_a[0] = 1'b1; ad_a[0] = 4'(k);
            tick();
            chk($sformatf("clear_word%0d", k), {8'h0, q_a0}, 16'h00A5);
        end
        idle();

        // RDW_OLD on instance 0
        wr_a[0] = 1'b1; ad_a[0] = 4'd2; d_a[0] = 16'h0011; be_a[0] = 2'b01;
        tick();
        rd_a[0] = 1'b1; d_a[0] = 16'h0022;
        tick();
        chk("rdw_old", {8'h0, q_a0}, 16'h0011);
        wr_a[0] = 1'b0;
        tick();
        chk("rdw_old_after", {8'h0, q_a0}, 16'h0022);
        idle();

        // Full-lane collision on address 7
        wr_a[0] = 1'b1; ad_a[0] = 4'd7; d_a[0] = 16'h0001; be_a[0] = 2'b01;
        wr_b[0] = 1'b1; ad_b[0] = 4'd7; d_b[0] = 16'h0002; be_b[0] = 2'b01;
        tick();
        chk("coll_pulse", {15'h0, coll0}, 16'h0001);
        idle();
        rd_a[0] = 1'b1; ad_a[0] = 4'd7;
        tick();
        chk("coll_one_cycle", {15'h0, coll0}, 16'h0000);
        chk("coll_a_wins", {8'h0, q_a0}, 16'h0001);
        idle();
        repeat (150) begin
            rand_port(0, 0, 3);
            tick();
        end
        idle();

        // Instance 1: fill, byte enables, RDW_NEW, partial collision
        for (int k = 0; k < 16; k++) begin
            wr_a[1] = 1'b1; ad_a[1] = 4'(k); d_a[1] = 16'(k * 16'h0101); be_a[1] = 2'b11;
            tick();
        end
        wr_a[1] = 1'b1; ad_a[1] = 4'd3; d_a[1] = 16'h1234; be_a[1] = 2'b11;
        tick();
        d_a[1] = 16'hABCD; be_a[1] = 2'b10;
        tick();
        wr_a[1] = 1'b0; rd_a[1] = 1'b1;
        tick();
        chk("byteena_merge", q_a1, 16'hAB34);
        wr_a[1] = 1'b1; rd_a[1] = 1'b0; ad_a[1] = 4'd4; d_a[1] = 16'h0011; be_a[1] = 2'b11;
        tick();
        rd_a[1] = 1'b1; d_a[1] = 16'h0022;
        tick();
        chk("rdw_new", q_a1, 16'h0022);
        idle();
        wr_a[1] = 1'b1; ad_a[1] = 4'd9; d_a[1] = 16'h1111; be_a[1] = 2'b01;
        wr_b[1] = 1'b1; ad_b[1] = 4'd9; d_b[1] = 16'h2222; be_b[1] = 2'b11;
        tick();
        chk("coll_partial_pulse", {15'h0, coll1}, 16'h0001);
        idle();
        rd_b[1] = 1'b1; ad_b[1] = 4'd9;
        tick();
        chk("coll_partial_word", q_b1, 16'h2211);
        idle();
        repeat (150) begin
            rand_port(1, 0, 3);
            tick();
        end
        idle();

        // Instance 2: output register latency, hold, RDW_KEEP, out-of-range
        for (int k = 0; k < 12; k++) begin
            wr_b[2] = 1'b1; ad_b[2] = 4'(k); d_b[2] = 16'(8'h30 + k); be_b[2] = 2'b01;
            tick();
        end
        idle();
        wr_a[2] = 1'b1; ad_a[2] = 4'd1; d_a[2] = 16'h0055; be_a[2] = 2'b01;
        tick();
        idle();
        rd_a[2] = 1'b1; ad_a[2] = 4'd1;
        tick();
        chk("oreg_lat1", {8'h0, q_a2}, 16'h0000);
        rd_a[2] = 1'b0;
        tick();
        chk("oreg_lat2", {8'h0, q_a2}, 16'h0055);
        tick();
        chk("oreg_hold", {8'h0, q_a2}, 16'h0055);
        wr_a[2] = 1'b1; ad_a[2] = 4'd2; d_a[2] = 16'h0011; be_a[2] = 2'b01;
        tick();
        rd_a[2] = 1'b1; d_a[2] = 16'h0022;
        tick();
        idle();
        tick();
        chk("rdw_keep", {8'h0, q_a2}, 16'h0055);
        rd_a[2] = 1'b1; ad_a[2] = 4'd2;
        tick();
        rd_a[2] = 1'b0;
        tick();
        chk("keep_then_read", {8'h0, q_a2}, 16'h0022);
        wr_a[2] = 1'b1; ad_a[2] = 4'd13; d_a[2] = 16'h0077; be_a[2] = 2'b01;
        tick();
        wr_a[2] = 1'b0; rd_a[2] = 1'b1;
        tick();
        rd_a[2] = 1'b0;
        tick();
        chk("oor_read_zero", {8'h0, q_a2}, 16'h0000);
        rd_a[2] = 1'b1; ad_a[2] = 4'd1;
        tick();
        rd_a[2] = 1'b0;
        tick();
        chk("oor_write_ignored", {8'h0, q_a2}, 16'h0055);
        repeat (150) begin
            rand_port(2, 8, 15);
            tick();
        end
        idle();

        // Reset mid-clear at address 9, writes while busy are dropped
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        tick();
        rst = 1'b0;
        repeat (9) tick();
        chk("clr_addr9_busy", {15'h0, busy0}, 16'h0001);
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        tick();
        rst = 1'b0;
        wr_a[0] = 1'b1; ad_a[0] = 4'd5; d_a[0] = 16'h003C; be_a[0] = 2'b01;
        rd_b[0] = 1'b1; ad_b[0] = 4'd5;
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("clear_restart_cycles", 16'(n), 16'd16);
        idle();
        rd_a[0] = 1'b1; ad_a[0] = 4'd5;
        tick();
        chk("write_dropped_busy", {8'h0, q_a0}, 16'h00A5);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
